// File: rtl/mips_pkg.sv
// mips_pkg: shared opcodes, control-field codes, FSM states and control word for the MIPS32 multi-cycle control unit.
package mips_pkg;
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] FN_JR    = 6'h08;

    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_FUNCT = 3'd2;
    localparam logic [2:0] ALU_AND   = 3'd3;
    localparam logic [2:0] ALU_OR    = 3'd4;
    localparam logic [2:0] ALU_SLT   = 3'd5;

    localparam logic [1:0] PCS_ALU    = 2'd0;
    localparam logic [1:0] PCS_ALUOUT = 2'd1;
    localparam logic [1:0] PCS_JUMP   = 2'd2;
    localparam logic [1:0] PCS_RS     = 2'd3;

    localparam logic [1:0] SRCB_RT     = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    localparam logic [1:0] DST_RT = 2'd0;
    localparam logic [1:0] DST_RD = 2'd1;
    localparam logic [1:0] DST_RA = 2'd2;

    typedef enum logic [3:0] {
        S_HALT, S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I, S_ADDR,
        S_MEM_RD, S_WB_MEM, S_MEM_WR, S_BRANCH, S_JUMP, S_JR, S_ERROR
    } state_e;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic [1:0] reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_source;
        logic       branch_ne;
    } ctrl_t;

    // Opcode dispatch out of DECODE; anything unrecognised is fatal.
    function automatic state_e dispatch(input logic [5:0] op, input logic [5:0] fn, input logic [5:0] halt_op);
        return (op == OP_RTYPE) ? ((fn == FN_JR) ? S_JR : S_EXEC_R) :
               (op == OP_LW || op == OP_SW) ? S_ADDR :
               (op == OP_BEQ || op == OP_BNE) ? S_BRANCH :
               (op == OP_J || op == OP_JAL) ? S_JUMP :
               (op == OP_ADDI || op == OP_ANDI || op == OP_ORI || op == OP_SLTI) ? S_EXEC_I :
               (op == halt_op) ? S_HALT : S_ERROR;
    endfunction
endpackage

// File: rtl/mips_ctrl_decode.sv
// mips_ctrl_decode: combinational state/opcode to datapath control-word lookup.
module mips_ctrl_decode
    import mips_pkg::*;
#(
    parameter int OPCODE_W = 6
) (
    input  state_e              state,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output ctrl_t               ctrl
);
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
                ctrl.alu_src_b = mem_ready ? SRCB_FOUR : SRCB_RT;
            end
            S_DECODE: ctrl.alu_src_b = SRCB_IMM_SH;
            S_EXEC_R: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_WB_R: begin
                ctrl.reg_dst   = DST_RD;
                ctrl.reg_write = 1'b1;
            end
            S_EXEC_I: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = (opcode == OP_ANDI) ? ALU_AND :
                                 (opcode == OP_ORI)  ? ALU_OR  :
                                 (opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
            end
            S_WB_I: ctrl.reg_write = 1'b1;
            S_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_WB_MEM: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
            end
            S_MEM_WR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_op        = ALU_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCS_ALUOUT;
                ctrl.branch_ne     = (opcode == OP_BNE);
            end
            S_JUMP: begin
                // jal links PC (already PC+4) into $31 via the RegDst = 2 route
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCS_JUMP;
                ctrl.reg_write = (opcode == OP_JAL);
                ctrl.reg_dst   = (opcode == OP_JAL) ? DST_RA : DST_RT;
            end
            S_JR: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCS_RS;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: multi-cycle MIPS32 control FSM with memory-wait timeout,
// run/halt/single-step control and a halt opcode.
module mips_multicycle_ctrl
    import mips_pkg::*;
#(
    parameter int                  OPCODE_W    = 6,
    parameter int                  TIMEOUT_W   = 8,
    parameter logic [OPCODE_W-1:0] HALT_OPCODE = 6'h3F,
    parameter bit                  STEP_EN     = 1'b1
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic [OPCODE_W-1:0] OpCode,
    input  logic [OPCODE_W-1:0] Funct,
    input  logic                Zero,
    input  logic                MemReady,
    input  logic                Run,
    input  logic                Step,
    output logic                PCWrite,
    output logic                PCWriteCond,
    output logic                IorD,
    output logic                IRWrite,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                MemToReg,
    output logic [1:0]          RegDst,
    output logic                RegWrite,
    output logic                ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [2:0]          ALUOp,
    output logic [1:0]          PCSource,
    output logic                BranchNe,
    output logic                Halted,
    output logic                Error,
    output logic [3:0]          State
);
    localparam logic [TIMEOUT_W-1:0] WAIT_LAST = {{(TIMEOUT_W-1){1'b1}}, 1'b0};

    state_e               state;
    state_e               retire_to;
    logic                 step_flag;
    logic                 step_go;
    logic [TIMEOUT_W-1:0] wait_cnt;
    ctrl_t                ctrl;
    logic                 unused_zero;

    // Zero is consumed by the datapath through PCWriteCond/BranchNe
    assign unused_zero = Zero;
    assign step_go     = STEP_EN & Step;
    assign retire_to   = (Run && !step_flag) ? S_FETCH : S_HALT;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state     <= S_HALT;
            step_flag <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            wait_cnt <= '0;
            case (state)
                S_HALT: begin
                    state     <= (Run || step_go) ? S_FETCH : S_HALT;
                    step_flag <= step_go && !Run;
                end
                S_FETCH, S_MEM_RD, S_MEM_WR: begin
                    if (MemReady)
                        state <= (state == S_FETCH) ? S_DECODE : (state == S_MEM_RD) ? S_WB_MEM : retire_to;
                    else if (wait_cnt == WAIT_LAST)
                        state <= S_ERROR;
                    else
                        wait_cnt <= wait_cnt + 1'b1;
                end
                S_DECODE: state <= dispatch(OpCode, Funct, HALT_OPCODE);
                S_EXEC_R: state <= S_WB_R;
                S_EXEC_I: state <= S_WB_I;
                S_ADDR:   state <= (OpCode == OP_SW) ? S_MEM_WR : S_MEM_RD;
                S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP, S_JR: state <= retire_to;
                default:  state <= S_ERROR;
            endcase
        end
    end

    mips_ctrl_decode #(.OPCODE_W(OPCODE_W)) u_decode (
        .state     (state),
        .opcode    (OpCode),
        .mem_ready (MemReady),
        .ctrl      (ctrl)
    );

    assign PCWrite     = ctrl.pc_write;
    assign PCWriteCond = ctrl.pc_write_cond;
    assign IorD        = ctrl.i_or_d;
    assign IRWrite     = ctrl.ir_write;
    assign MemRead     = ctrl.mem_read;
    assign MemWrite    = ctrl.mem_write;
    assign MemToReg    = ctrl.mem_to_reg;
    assign RegDst      = ctrl.reg_dst;
    assign RegWrite    = ctrl.reg_write;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign ALUOp       = ctrl.alu_op;
    assign PCSource    = ctrl.pc_source;
    assign BranchNe    = ctrl.branch_ne;
    assign Halted      = (state == S_HALT);
    assign Error       = (state == S_ERROR);
    assign State       = state;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: directed vectors into a scoreboard queue, checked by a negedge monitor.
module tb_mips_multicycle_ctrl;
    import mips_pkg::*;

    logic       Clk = 1'b0, Rst = 1'b1;
    logic [5:0] OpCode = '0, Funct = '0;
    logic       Zero = 1'b0, MemReady = 1'b0, Run = 1'b0, Step = 1'b0;
    logic       PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite, MemToReg;
    logic [1:0] RegDst, ALUSrcB, PCSource;
    logic       RegWrite, ALUSrcA, BranchNe, Halted, Error;
    logic [2:0] ALUOp;
    logic [3:0] State;
    logic [18:0] obs;

    mips_multicycle_ctrl dut (
        .Clk(Clk), .Rst(Rst), .OpCode(OpCode), .Funct(Funct), .Zero(Zero),
        .MemReady(MemReady), .Run(Run), .Step(Step),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .IRWrite(IRWrite),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemToReg(MemToReg), .RegDst(RegDst),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .PCSource(PCSource), .BranchNe(BranchNe), .Halted(Halted), .Error(Error), .State(State)
    );

    always #5 Clk = ~Clk;

    assign obs = {PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite, MemToReg,
                  RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, BranchNe};

    localparam logic [18:0] C_BNE = 19'h00001, C_SA = 19'h00100, C_RW = 19'h00200;
    localparam logic [18:0] C_M2R = 19'h01000, C_MW = 19'h02000, C_MR = 19'h04000;
    localparam logic [18:0] C_IRW = 19'h08000, C_IORD = 19'h10000, C_PCWC = 19'h20000, C_PCW = 19'h40000;

    function automatic logic [18:0] ps(input int n);  return 19'(n) << 1;  endfunction
    function automatic logic [18:0] aop(input int n); return 19'(n) << 3;  endfunction
    function automatic logic [18:0] sb(input int n);  return 19'(n) << 6;  endfunction
    function automatic logic [18:0] rd(input int n);  return 19'(n) << 10; endfunction

    typedef struct {
        string      nm;
        logic [3:0] st;
        logic [18:0] cw;
    } exp_t;

    exp_t q[$];
    int n_vec = 0, n_bad = 0;
    logic [18:0] f_rdy;

    always @(negedge Clk) begin
        if (q.size() != 0) begin
            exp_t e;
            e = q.pop_front();
            n_vec++;
            if (State !== e.st || obs !== e.cw || Halted !== (e.st == S_HALT) || Error !== (e.st == S_ERROR)) begin
                n_bad++;
                $display("FAIL %s: got state=%0d ctrl=%05h halted=%b error=%b, expected state=%0d ctrl=%05h",
                         e.nm, State, obs, Halted, Error, e.st, e.cw);
            end
        end
    end

    task automatic vec(input string nm, input logic run, input logic mrdy, input state_e st, input logic [18:0] cw);
        exp_t e;
        Run = run;
        MemReady = mrdy;
        e.nm = nm;
        e.st = st;
        e.cw = cw;
        q.push_back(e);
        @(posedge Clk);
        #1;
    endtask

    task automatic fd(input string p);
        vec({p, "_fetch"}, 1'b1, 1'b1, S_FETCH, f_rdy);
        vec({p, "_decode"}, 1'b1, 1'b1, S_DECODE, sb(3));
    endtask

    initial begin
        f_rdy = C_MR | C_IRW | C_PCW | sb(1);
        @(posedge Clk);
        #1;
        if (State !== S_HALT || Halted !== 1'b1 || Error !== 1'b0 || obs !== '0) begin
            n_bad++;
            $display("FAIL reset_state: state=%0d ctrl=%05h halted=%b error=%b", State, obs, Halted, Error);
        end
        vec("reset", 1'b0, 1'b0, S_HALT, '0);
        Rst = 1'b0;
        vec("idle0", 1'b0, 1'b0, S_HALT, '0);
        vec("idle1", 1'b0, 1'b0, S_HALT, '0);
        vec("go", 1'b1, 1'b1, S_HALT, '0);
        OpCode = OP_RTYPE; Funct = 6'h20;
        fd("add");
        vec("add_exec", 1'b1, 1'b1, S_EXEC_R, C_SA | aop(2));
        vec("add_wb", 1'b1, 1'b1, S_WB_R, C_RW | rd(1));
        OpCode = OP_LW;
        fd("lw");
        vec("lw_addr", 1'b1, 1'b1, S_ADDR, C_SA | sb(2));
        for (int i = 0; i < 3; i++) vec("lw_wait", 1'b1, 1'b0, S_MEM_RD, C_MR | C_IORD);
        vec("lw_mem", 1'b1, 1'b1, S_MEM_RD, C_MR | C_IORD);
        vec("lw_wb", 1'b1, 1'b1, S_WB_MEM, C_M2R | C_RW);
        OpCode = OP_BEQ; Zero = 1'b1;
        fd("beq");
        vec("beq_br", 1'b1, 1'b1, S_BRANCH, C_SA | aop(1) | C_PCWC | ps(1));
        OpCode = OP_BNE; Zero = 1'b0;
        vec("bne_fetch", 1'b1, 1'b1, S_FETCH, f_rdy);
        vec("bne_decode", 1'b0, 1'b1, S_DECODE, sb(3));
        vec("bne_br", 1'b0, 1'b1, S_BRANCH, C_SA | aop(1) | C_PCWC | ps(1) | C_BNE);
        vec("bne_halt", 1'b0, 1'b1, S_HALT, '0);
        OpCode = OP_ADDI;
        Step = 1'b1;
        vec("step_halt", 1'b0, 1'b1, S_HALT, '0);
        Step = 1'b0;
        vec("step_fetch", 1'b0, 1'b1, S_FETCH, f_rdy);
        Step = 1'b1;
        vec("step_decode", 1'b0, 1'b1, S_DECODE, sb(3));
        Step = 1'b0;
        vec("step_exec", 1'b0, 1'b1, S_EXEC_I, C_SA | sb(2));
        vec("step_wb", 1'b0, 1'b1, S_WB_I, C_RW);
        vec("step_back", 1'b0, 1'b1, S_HALT, '0);
        vec("step_stay", 1'b0, 1'b1, S_HALT, '0);
        vec("go2", 1'b1, 1'b1, S_HALT, '0);
        OpCode = OP_ORI;
        fd("ori");
        vec("ori_exec", 1'b1, 1'b1, S_EXEC_I, C_SA | sb(2) | aop(4));
        vec("ori_wb", 1'b1, 1'b1, S_WB_I, C_RW);
        OpCode = OP_JAL;
        fd("jal");
        vec("jal_jump", 1'b1, 1'b1, S_JUMP, C_PCW | ps(2) | C_RW | rd(2));
        OpCode = OP_RTYPE; Funct = FN_JR;
        fd("jr");
        vec("jr_jump", 1'b1, 1'b1, S_JR, C_PCW | ps(3));
        OpCode = OP_SW;
        fd("sw");
        vec("sw_addr", 1'b1, 1'b1, S_ADDR, C_SA | sb(2));
        vec("sw_mem", 1'b1, 1'b1, S_MEM_WR, C_MW | C_IORD);
        OpCode = 6'h3F;
        fd("hop");
        vec("hop_halt", 1'b0, 1'b1, S_HALT, '0);
        vec("go3", 1'b1, 1'b1, S_HALT, '0);
        OpCode = 6'h3E;
        fd("ill");
        vec("ill_err", 1'b1, 1'b1, S_ERROR, '0);
        Step = 1'b1;
        vec("err_hold", 1'b1, 1'b1, S_ERROR, '0);
        Step = 1'b0;
        Rst = 1'b1;
        vec("rst_err", 1'b1, 1'b1, S_HALT, '0);
        Rst = 1'b0;
        vec("go4", 1'b1, 1'b0, S_HALT, '0);
        vec("fwait0", 1'b1, 1'b0, S_FETCH, C_MR);
        vec("fwait1", 1'b1, 1'b0, S_FETCH, C_MR);
        Rst = 1'b1;
        vec("rst_mid", 1'b1, 1'b0, S_HALT, '0);
        Rst = 1'b0;
        vec("go5", 1'b1, 1'b0, S_HALT, '0);
        for (int i = 0; i < 255; i++) vec("to_wait", 1'b1, 1'b0, S_FETCH, C_MR);
        if (State !== S_ERROR || Error !== 1'b1 || Halted !== 1'b0 || obs !== '0) begin
            n_bad++;
            $display("FAIL timeout_expired: state=%0d ctrl=%05h halted=%b error=%b", State, obs, Halted, Error);
        end
        vec("to_err", 1'b1, 1'b0, S_ERROR, '0);
        vec("to_hold", 1'b0, 1'b1, S_ERROR, '0);
        Rst = 1'b1;
        vec("rst_final", 1'b0, 1'b0, S_HALT, '0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
